// File: rtl/alu_pkg.sv
// Shared types, frame constants and checksum helpers for the serial ALU core.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  localparam logic DATA_TYPE = 1'b0;
  localparam logic CMD_TYPE  = 1'b1;

  // Bit positions inside the 3-bit error vector {data, crc, op}
  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  // Receiver samples type + 8 payload bits before the stop bit
  localparam logic [3:0] RX_BITS_BEFORE_STOP = 4'd9;
  // Serializer drives type + 8 payload + stop after the start bit
  localparam logic [3:0] TX_BITS_AFTER_START = 4'd10;

  localparam logic [3:0] DATA_FRAMES  = 4'd8;
  localparam logic [3:0] DATA_CNT_MAX = 4'd9;
  // Index of the trailing CMD frame in a normal response
  localparam logic [2:0] RSP_LAST_IDX = 3'd4;

  // x^4+x+1, init 0, MSB of the vector first
  function automatic logic [3:0] crc4_generate(input logic [67:0] i_data);
    logic [3:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ i_data[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return crc;
  endfunction

  // x^3+x+1, init 0, MSB of the vector first
  function automatic logic [2:0] crc3_generate(input logic [36:0] i_data);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ i_data[i];
      crc = {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_serial_tx.sv
// Frame serializer: start 0, type, 8 payload bits MSB first, stop 1.
// o_done is high while the stop bit is on the line so a load in that cycle
// puts the next start bit directly behind it.
module alu_serial_tx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_type,
  input  logic [7:0] i_byte,
  output logic       o_sout,
  output logic       o_done
);
  import alu_pkg::*;

  logic [9:0] r_shift;
  logic [3:0] r_bits;
  logic       r_active;
  logic       r_sout;

  // Shift out one bit per clock; line rests high when nothing is loaded
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift  <= '1;
      r_bits   <= '0;
      r_active <= 1'b0;
      r_sout   <= 1'b1;
    end else if (i_load) begin
      r_sout   <= 1'b0;
      r_shift  <= {i_type, i_byte, 1'b1};
      r_bits   <= TX_BITS_AFTER_START;
      r_active <= 1'b1;
    end else if (r_bits != 4'd0) begin
      r_sout   <= r_shift[9];
      r_shift  <= {r_shift[8:0], 1'b1};
      r_bits   <= r_bits - 4'd1;
    end else begin
      r_active <= 1'b0;
      r_sout   <= 1'b1;
    end
  end

  assign o_sout = r_sout;
  assign o_done = r_active && (r_bits == 4'd0);

endmodule

// File: rtl/alu_serial_core.sv
// Serial ALU: collects 8 DATA operand frames and a CMD frame, validates,
// computes C = f(B, A) and answers with a serial response frame sequence.
//
//   state   | meaning
//   COLLECT | receiver armed, DATA bytes buffered, waits for CMD frame
//   CHECK   | latch error flags (DATA > CRC > OP)
//   CALC    | latch response checksum; may start TX if the gap has elapsed
//   GAP     | wait out the remaining response gap
//   TX      | drive response frames back-to-back
//
// The gap counter starts at the CMD stop bit, so RSP_GAP must be >= 2 to
// leave room for CHECK and CALC. CALC goes straight to TX when the gap
// already expired during it (always the case for RSP_GAP = 2).
module alu_serial_core #(
  parameter int unsigned RSP_GAP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  output logic sout
);
  import alu_pkg::*;

  localparam int GAP_W = (RSP_GAP > 1) ? $clog2(RSP_GAP) : 1;

  typedef enum logic [2:0] {ST_COLLECT, ST_CHECK, ST_CALC, ST_GAP, ST_TX} ctrl_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_WAIT_HIGH} rx_state_t;

  ctrl_state_t r_state;
  rx_state_t   r_rx_state;
  logic [3:0]  r_rx_cnt;
  logic [8:0]  r_rx_sr;

  logic [63:0]      r_buf;
  logic [3:0]       r_dcnt;
  logic [31:0]      r_b;
  logic [31:0]      r_a;
  logic [2:0]       r_op;
  logic [3:0]       r_crc_rx;
  logic [3:0]       r_snap_cnt;
  logic [2:0]       r_err;
  logic [2:0]       r_crc3;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [2:0]       r_tx_idx;

  logic        w_rx_done;
  logic        w_rx_type;
  logic [7:0]  w_rx_byte;
  logic [31:0] w_c;
  logic        w_carry;
  logic        w_ovf;
  logic        w_op_ok;
  logic [3:0]  w_flags;
  logic [3:0]  w_crc4;
  logic [2:0]  w_crc3;
  logic [2:0]  w_err_next;
  logic [2:0]  w_err_bits;
  logic [6:0]  w_err_head;
  logic [7:0]  w_err_payload;
  logic        w_gap_done;
  logic        w_tx_start;
  logic        w_tx_last;
  logic        w_tx_done;
  logic        w_tx_load;
  logic [2:0]  w_load_idx;
  logic        w_tx_type;
  logic [7:0]  w_tx_byte;

  assign w_rx_done = (r_rx_state == RX_BITS) && (r_rx_cnt == 4'd0) && sin;
  assign w_rx_type = r_rx_sr[8];
  assign w_rx_byte = r_rx_sr[7:0];

  // Frame receiver; held idle outside COLLECT so traffic during a response is dropped
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_COLLECT)) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_sr    <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!sin) begin
            r_rx_state <= RX_BITS;
            r_rx_cnt   <= RX_BITS_BEFORE_STOP;
          end
        end
        RX_BITS: begin
          if (r_rx_cnt != 4'd0) begin
            r_rx_sr  <= {r_rx_sr[7:0], sin};
            r_rx_cnt <= r_rx_cnt - 4'd1;
          end else begin
            r_rx_state <= sin ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (sin) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ALU on the operands captured at CMD completion; they stay put until the next CMD
  always_comb begin
    w_c     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_op_ok = 1'b1;
    case (r_op)
      OP_AND: w_c = r_b & r_a;
      OP_OR:  w_c = r_b | r_a;
      OP_ADD: begin
        {w_carry, w_c} = {1'b0, r_b} + {1'b0, r_a};
        w_ovf = (r_b[31] == r_a[31]) && (w_c[31] != r_b[31]);
      end
      OP_SUB: begin
        w_c     = r_b - r_a;
        w_carry = (r_b < r_a);
        w_ovf   = (r_b[31] != r_a[31]) && (w_c[31] != r_b[31]);
      end
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_flags = {w_carry, w_ovf, (w_c == 32'd0), w_c[31]};
  assign w_crc4  = crc4_generate({r_b, r_a, 1'b1, r_op});
  assign w_crc3  = crc3_generate({w_c, 1'b0, w_flags});

  // Only the highest-priority error is reported
  always_comb begin
    w_err_next = '0;
    if (r_snap_cnt != DATA_FRAMES)  w_err_next[ERR_DATA_BIT] = 1'b1;
    else if (w_crc4 != r_crc_rx)    w_err_next[ERR_CRC_BIT]  = 1'b1;
    else if (!w_op_ok)              w_err_next[ERR_OP_BIT]   = 1'b1;
  end

  assign w_err_bits    = {r_err[ERR_DATA_BIT], r_err[ERR_CRC_BIT], r_err[ERR_OP_BIT]};
  assign w_err_head    = {1'b1, w_err_bits, w_err_bits};
  assign w_err_payload = {w_err_head, ^w_err_head};

  assign w_gap_done = (r_gap_cnt == '0);
  assign w_tx_start = ((r_state == ST_CALC) || (r_state == ST_GAP)) && w_gap_done;
  assign w_tx_last  = (|r_err) || (r_tx_idx == RSP_LAST_IDX);
  assign w_tx_load  = w_tx_start || ((r_state == ST_TX) && w_tx_done && !w_tx_last);
  assign w_load_idx = w_tx_start ? 3'd0 : (r_tx_idx + 3'd1);

  // Select the frame to hand the serializer on each load
  always_comb begin
    w_tx_type = DATA_TYPE;
    w_tx_byte = '0;
    if (|r_err) begin
      w_tx_type = CMD_TYPE;
      w_tx_byte = w_err_payload;
    end else if (w_load_idx == RSP_LAST_IDX) begin
      w_tx_type = CMD_TYPE;
      w_tx_byte = {1'b0, w_flags, r_crc3};
    end else begin
      case (w_load_idx)
        3'd0:    w_tx_byte = w_c[31:24];
        3'd1:    w_tx_byte = w_c[23:16];
        3'd2:    w_tx_byte = w_c[15:8];
        default: w_tx_byte = w_c[7:0];
      endcase
    end
  end

  // Control FSM: operand collection, checking, gap timing and response sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_COLLECT;
      r_buf      <= '0;
      r_dcnt     <= '0;
      r_b        <= '0;
      r_a        <= '0;
      r_op       <= '0;
      r_crc_rx   <= '0;
      r_snap_cnt <= '0;
      r_err      <= '0;
      r_crc3     <= '0;
      r_gap_cnt  <= '0;
      r_tx_idx   <= '0;
    end else begin
      if ((r_state != ST_COLLECT) && (r_state != ST_TX) && !w_gap_done)
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      case (r_state)
        ST_COLLECT: begin
          if (w_rx_done) begin
            if (w_rx_type == DATA_TYPE) begin
              if (r_dcnt < DATA_FRAMES) r_buf <= {r_buf[55:0], w_rx_byte};
              if (r_dcnt != DATA_CNT_MAX) r_dcnt <= r_dcnt + 4'd1;
            end else begin
              r_b        <= r_buf[63:32];
              r_a        <= r_buf[31:0];
              r_op       <= w_rx_byte[6:4];
              r_crc_rx   <= w_rx_byte[3:0];
              r_snap_cnt <= r_dcnt;
              r_buf      <= '0;
              r_dcnt     <= '0;
              r_gap_cnt  <= GAP_W'(RSP_GAP - 1);
              r_state    <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          r_err   <= w_err_next;
          r_state <= (|w_err_next) ? ST_GAP : ST_CALC;
        end
        ST_CALC: begin
          r_crc3 <= w_crc3;
          if (w_gap_done) begin
            r_tx_idx <= '0;
            r_state  <= ST_TX;
          end else begin
            r_state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_tx_idx <= '0;
            r_state  <= ST_TX;
          end
        end
        ST_TX: begin
          if (w_tx_done) begin
            if (w_tx_last) r_state  <= ST_COLLECT;
            else           r_tx_idx <= r_tx_idx + 3'd1;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  alu_serial_tx u_tx (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_tx_load),
    .i_type (w_tx_type),
    .i_byte (w_tx_byte),
    .o_sout (sout),
    .o_done (w_tx_done)
  );

endmodule
